vga_pattern_ctrl: RTL

UART command controller that configures the VGA test-pattern generator. It parses ASCII commands from the UART receiver. It holds a requested pattern until the next frame boundary so the picture never changes mid-frame, and it can auto-cycle patterns every N frames. Each command is answered with one reply byte through the UART transmitter. It sits between the UART RX/TX pair and the test-pattern block's pattern-select input.

---
 rtl/vga_ctrl_pkg.sv | 45 ++++
 rtl/uart_reply_slot.sv | 55 +++++
 rtl/vga_pattern_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/vga_ctrl_pkg.sv
// Shared constants, state encodings and ASCII helpers for the VGA pattern
// command controller.
package vga_ctrl_pkg;

  localparam logic [7:0] ASCII_P  = 8'h50;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_Q  = 8'h3F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    PS_IDLE  = 2'd0,
    PS_GOT_P = 2'd1,
    PS_GOT_A = 2'd2
  } parse_state_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_e;

  // Returns {valid, nibble}; valid is 0 for anything outside 0-9, A-F, a-f.
  function automatic logic [4:0] hex_to_nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, 4'(c - 8'h30)};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      r = {1'b1, 4'(c - 8'h37)};
    end else if (c >= 8'h61 && c <= 8'h66) begin
      r = {1'b1, 4'(c - 8'h57)};
    end
    return r;
  endfunction

  function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
    logic [7:0] r;
    if (n < 4'd10) r = 8'h30 + 8'(n);
    else           r = 8'h37 + 8'(n);
    return r;
  endfunction

endpackage

// File: rtl/uart_reply_slot.sv
// Single-entry reply buffer feeding the UART transmitter; a newer reply
// overwrites one that has not been issued yet.
module uart_reply_slot
  import vga_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr,
  input  logic [7:0] i_byte,
  input  logic       i_tx_done,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte
);

  tx_state_e  r_state;
  logic       r_slot_vld;
  logic [7:0] r_slot_byte;
  logic       r_tx_dv;
  logic [7:0] r_tx_byte;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= TX_IDLE;
      r_slot_vld  <= 1'b0;
      r_slot_byte <= 8'h00;
      r_tx_dv     <= 1'b0;
      r_tx_byte   <= 8'h00;
    end else begin
      r_tx_dv <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          if (r_slot_vld) begin
            r_tx_dv    <= 1'b1;
            r_tx_byte  <= r_slot_byte;
            r_slot_vld <= 1'b0;
            r_state    <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (i_tx_done) r_state <= TX_IDLE;
        end
        default: r_state <= TX_IDLE;
      endcase
      // A write in the issue cycle lands after the old byte has been taken.
      if (i_wr) begin
        r_slot_vld  <= 1'b1;
        r_slot_byte <= i_byte;
      end
    end
  end

  assign o_tx_dv   = r_tx_dv;
  assign o_tx_byte = r_tx_byte;

endmodule

// File: rtl/vga_pattern_ctrl.sv
// UART command parser, frame-synchronous pattern scheduler and auto-cycle
// logic driving the VGA test-pattern select.
module vga_pattern_ctrl
  import vga_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = 8,
  parameter int unsigned TIMEOUT_CLKS = 2_500_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  input  logic       i_frame_tick,
  input  logic       i_tx_done,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  output logic [3:0] o_pattern,
  output logic       o_auto_en,
  output logic       o_cmd_err
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned NIB_W = 4;

  parse_state_e     r_ps;
  logic [TO_W-1:0]  r_to_cnt;
  logic [NIB_W-1:0] r_pattern;
  logic [NIB_W-1:0] r_pending_pat;
  logic             r_pending_vld;
  logic [NIB_W-1:0] r_auto_period;
  logic [NIB_W-1:0] r_frame_cnt;
  logic             r_auto_en;
  logic             r_cmd_err;

  parse_state_e     w_ps_nxt;
  logic [4:0]       w_hex;
  logic             w_byte_act;
  logic             w_timeout;
  logic             w_reply_wr;
  logic [7:0]       w_reply_byte;
  logic             w_pat_set;
  logic             w_auto_set;

  // Command decode: next parser state plus the reply to post this cycle.
  always_comb begin
    w_ps_nxt     = r_ps;
    w_reply_wr   = 1'b0;
    w_reply_byte = ASCII_E;
    w_pat_set    = 1'b0;
    w_auto_set   = 1'b0;
    w_hex        = hex_to_nib(i_rx_byte);
    w_byte_act   = i_rx_dv && (i_rx_byte != ASCII_CR) && (i_rx_byte != ASCII_LF);
    w_timeout    = (r_ps != PS_IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CLKS));
    case (r_ps)
      PS_IDLE: begin
        if (w_byte_act) begin
          if (i_rx_byte == ASCII_P) begin
            w_ps_nxt = PS_GOT_P;
          end else if (i_rx_byte == ASCII_A) begin
            w_ps_nxt = PS_GOT_A;
          end else if (i_rx_byte == ASCII_Q) begin
            w_reply_wr   = 1'b1;
            w_reply_byte = nib_to_ascii(r_pattern);
          end else begin
            w_reply_wr = 1'b1;
          end
        end
      end
      PS_GOT_P: begin
        if (w_byte_act) begin
          w_ps_nxt   = PS_IDLE;
          w_reply_wr = 1'b1;
          if (w_hex[4] && ({1'b0, w_hex[3:0]} < 5'(NUM_PATTERNS))) begin
            w_pat_set    = 1'b1;
            w_reply_byte = ASCII_K;
          end
        end else if (w_timeout) begin
          w_ps_nxt   = PS_IDLE;
          w_reply_wr = 1'b1;
        end
      end
      PS_GOT_A: begin
        if (w_byte_act) begin
          w_ps_nxt   = PS_IDLE;
          w_reply_wr = 1'b1;
          if (w_hex[4]) begin
            w_auto_set   = 1'b1;
            w_reply_byte = ASCII_K;
          end
        end else if (w_timeout) begin
          w_ps_nxt   = PS_IDLE;
          w_reply_wr = 1'b1;
        end
      end
      default: w_ps_nxt = PS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ps          <= PS_IDLE;
      r_to_cnt      <= '0;
      r_pattern     <= '0;
      r_pending_pat <= '0;
      r_pending_vld <= 1'b0;
      r_auto_period <= '0;
      r_frame_cnt   <= '0;
      r_auto_en     <= 1'b0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_ps      <= w_ps_nxt;
      r_cmd_err <= w_reply_wr && (w_reply_byte == ASCII_E);
      // Counter only runs while a command stays half-received.
      if ((r_ps != PS_IDLE) && (w_ps_nxt != PS_IDLE)) r_to_cnt <= r_to_cnt + TO_W'(1);
      else                                            r_to_cnt <= '0;

      if (i_frame_tick) begin
        if (r_pending_vld) begin
          r_pattern     <= r_pending_pat;
          r_pending_vld <= 1'b0;
          r_frame_cnt   <= '0;
        end else if (r_auto_en) begin
          if (r_frame_cnt == r_auto_period - NIB_W'(1)) begin
            r_pattern   <= (r_pattern == NIB_W'(NUM_PATTERNS - 1)) ? '0 : r_pattern + NIB_W'(1);
            r_frame_cnt <= '0;
          end else begin
            r_frame_cnt <= r_frame_cnt + NIB_W'(1);
          end
        end
      end

      // Commands completing alongside a tick wait for the following tick.
      if (w_pat_set) begin
        r_pending_pat <= w_hex[3:0];
        r_pending_vld <= 1'b1;
      end
      if (w_auto_set) begin
        r_auto_period <= w_hex[3:0];
        r_auto_en     <= (w_hex[3:0] != '0);
        r_frame_cnt   <= '0;
      end
    end
  end

  uart_reply_slot u_reply_slot (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr      (w_reply_wr),
    .i_byte    (w_reply_byte),
    .i_tx_done (i_tx_done),
    .o_tx_dv   (o_tx_dv),
    .o_tx_byte (o_tx_byte)
  );

  assign o_pattern = r_pattern;
  assign o_auto_en = r_auto_en;
  assign o_cmd_err = r_cmd_err;

endmodule
